// File: rtl/bonsai_sort_pkg.sv
// Shared helpers for the bitonic merge network: sizing, element slicing and
// the compare-and-swap decision used by every compare-exchange cell.
package bonsai_sort_pkg;

    // Widest key any cell compares; narrower keys are zero-extended into it
    localparam int MAX_KEY_WIDTH = 512;

    typedef logic [MAX_KEY_WIDTH-1:0] wide_key_t;

    // Ceiling log2, used to derive the number of pipeline stages from P
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit offset of element `index` inside a flat tuple of `width`-bit elements
    function automatic int elem_base(input int index, input int width);
        return index * width;
    endfunction

    // True when the element at the lower slot must trade places with the one
    // at the upper slot. Equal keys never swap, so the lower slot keeps its
    // element on ties (A stays low in the crossing stage, cleaners hold still).
    function automatic logic cas_swap(input wide_key_t key_lo,
                                      input wide_key_t key_hi,
                                      input logic      descending);
        if (descending) begin
            return key_lo < key_hi;
        end
        return key_lo > key_hi;
    endfunction

endpackage

// File: rtl/bitonic_merge_stage.sv
// One registered column of the bitonic merge pipeline. Stage 0 performs the
// crossing compare between the two input tuples; later stages run a half
// cleaner at distance P >> STAGE inside each half. Stall, valid and sideband
// ride along with the data under the same hold condition.
module bitonic_merge_stage
    import bonsai_sort_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int P          = 4,
    parameter bit DESCENDING = 1'b0,
    parameter int STAGE      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upstream_stall,
    input  logic                    upstream_valid,
    input  logic                    upstream_switch,
    input  logic [P*DATA_WIDTH-1:0] upstream_top,
    input  logic [P*DATA_WIDTH-1:0] upstream_lo,
    input  logic [P*DATA_WIDTH-1:0] upstream_hi,
    output logic                    stage_stall,
    output logic                    stage_valid,
    output logic                    stage_switch,
    output logic [P*DATA_WIDTH-1:0] stage_top,
    output logic [P*DATA_WIDTH-1:0] stage_lo,
    output logic [P*DATA_WIDTH-1:0] stage_hi
);

    logic [P*DATA_WIDTH-1:0] next_lo;
    logic [P*DATA_WIDTH-1:0] next_hi;

    if (STAGE == 0) begin : g_cross
        logic [DATA_WIDTH-1:0] elem_a;
        logic [DATA_WIDTH-1:0] elem_b;

        // Crossing compare: A[k] against B[P-1-k]; winner stays low, loser goes high
        always_comb begin
            next_lo = '0;
            next_hi = '0;
            elem_a  = '0;
            elem_b  = '0;
            for (int k = 0; k < P; k++) begin
                elem_a = upstream_lo[elem_base(k, DATA_WIDTH) +: DATA_WIDTH];
                elem_b = upstream_hi[elem_base(P - 1 - k, DATA_WIDTH) +: DATA_WIDTH];
                if (cas_swap(wide_key_t'(elem_a[KEY_WIDTH-1:0]),
                             wide_key_t'(elem_b[KEY_WIDTH-1:0]), DESCENDING)) begin
                    next_lo[elem_base(k, DATA_WIDTH) +: DATA_WIDTH]         = elem_b;
                    next_hi[elem_base(P - 1 - k, DATA_WIDTH) +: DATA_WIDTH] = elem_a;
                end else begin
                    next_lo[elem_base(k, DATA_WIDTH) +: DATA_WIDTH]         = elem_a;
                    next_hi[elem_base(P - 1 - k, DATA_WIDTH) +: DATA_WIDTH] = elem_b;
                end
            end
        end
    end else begin : g_clean
        localparam int DIST = P >> STAGE;

        logic [DATA_WIDTH-1:0] lo_i;
        logic [DATA_WIDTH-1:0] lo_j;
        logic [DATA_WIDTH-1:0] hi_i;
        logic [DATA_WIDTH-1:0] hi_j;

        // Half cleaner in both halves: pair i with i+DIST where that bit of i is clear
        always_comb begin
            next_lo = upstream_lo;
            next_hi = upstream_hi;
            lo_i    = '0;
            lo_j    = '0;
            hi_i    = '0;
            hi_j    = '0;
            for (int i = 0; i < P; i++) begin
                if ((i & DIST) == 0) begin
                    lo_i = upstream_lo[elem_base(i, DATA_WIDTH) +: DATA_WIDTH];
                    lo_j = upstream_lo[elem_base(i | DIST, DATA_WIDTH) +: DATA_WIDTH];
                    hi_i = upstream_hi[elem_base(i, DATA_WIDTH) +: DATA_WIDTH];
                    hi_j = upstream_hi[elem_base(i | DIST, DATA_WIDTH) +: DATA_WIDTH];
                    if (cas_swap(wide_key_t'(lo_i[KEY_WIDTH-1:0]),
                                 wide_key_t'(lo_j[KEY_WIDTH-1:0]), DESCENDING)) begin
                        next_lo[elem_base(i, DATA_WIDTH) +: DATA_WIDTH]        = lo_j;
                        next_lo[elem_base(i | DIST, DATA_WIDTH) +: DATA_WIDTH] = lo_i;
                    end
                    if (cas_swap(wide_key_t'(hi_i[KEY_WIDTH-1:0]),
                                 wide_key_t'(hi_j[KEY_WIDTH-1:0]), DESCENDING)) begin
                        next_hi[elem_base(i, DATA_WIDTH) +: DATA_WIDTH]        = hi_j;
                        next_hi[elem_base(i | DIST, DATA_WIDTH) +: DATA_WIDTH] = hi_i;
                    end
                end
            end
        end
    end

    // Stall bit always advances; everything else holds while the incoming stall is set
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_stall  <= 1'b0;
            stage_valid  <= 1'b0;
            stage_switch <= 1'b0;
            stage_top    <= '0;
            stage_lo     <= '0;
            stage_hi     <= '0;
        end else begin
            stage_stall <= upstream_stall;
            if (!upstream_stall) begin
                stage_valid  <= upstream_valid;
                stage_switch <= upstream_switch;
                stage_top    <= upstream_top;
                stage_lo     <= next_lo;
                stage_hi     <= next_hi;
            end
        end
    end

endmodule

// File: rtl/bitonic_merge_network_p.sv
// Pipelined P-way bitonic merger: two sorted P-element tuples in, the P
// smallest and P largest elements out after 1 + log2(P) register stages.
module bitonic_merge_network_p
    import bonsai_sort_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int P          = 4,
    parameter bit DESCENDING = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    stall,
    input  logic                    i_valid,
    input  logic                    switch_output,
    input  logic [P*DATA_WIDTH-1:0] top_tuple,
    input  logic [P*DATA_WIDTH-1:0] i_elems_0,
    input  logic [P*DATA_WIDTH-1:0] i_elems_1,
    output logic [P*DATA_WIDTH-1:0] o_elems_0,
    output logic [P*DATA_WIDTH-1:0] o_elems_1,
    output logic                    o_valid,
    output logic                    o_stall,
    output logic                    o_switch_output,
    output logic [P*DATA_WIDTH-1:0] o_top_tuple
);

    localparam int LAT = 1 + log2(P);

    // Index s holds what enters stage s; index LAT is the network output
    logic [LAT:0]            stall_chain;
    logic [LAT:0]            valid_chain;
    logic [LAT:0]            switch_chain;
    logic [P*DATA_WIDTH-1:0] top_chain [LAT+1];
    logic [P*DATA_WIDTH-1:0] lo_chain  [LAT+1];
    logic [P*DATA_WIDTH-1:0] hi_chain  [LAT+1];

    assign stall_chain[0]  = stall;
    assign valid_chain[0]  = i_valid;
    assign switch_chain[0] = switch_output;
    assign top_chain[0]    = top_tuple;
    assign lo_chain[0]     = i_elems_0;
    assign hi_chain[0]     = i_elems_1;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        bitonic_merge_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .KEY_WIDTH  (KEY_WIDTH),
            .P          (P),
            .DESCENDING (DESCENDING),
            .STAGE      (s)
        ) u_stage (
            .clk             (i_clk),
            .rst             (i_rst),
            .upstream_stall  (stall_chain[s]),
            .upstream_valid  (valid_chain[s]),
            .upstream_switch (switch_chain[s]),
            .upstream_top    (top_chain[s]),
            .upstream_lo     (lo_chain[s]),
            .upstream_hi     (hi_chain[s]),
            .stage_stall     (stall_chain[s+1]),
            .stage_valid     (valid_chain[s+1]),
            .stage_switch    (switch_chain[s+1]),
            .stage_top       (top_chain[s+1]),
            .stage_lo        (lo_chain[s+1]),
            .stage_hi        (hi_chain[s+1])
        );
    end

    assign o_elems_0       = lo_chain[LAT];
    assign o_elems_1       = hi_chain[LAT];
    assign o_valid         = valid_chain[LAT];
    assign o_stall         = stall_chain[LAT];
    assign o_switch_output = switch_chain[LAT];
    assign o_top_tuple     = top_chain[LAT];

endmodule

// File: tb/tb_bitonic_merge_network_p.sv
// Self-checking bench for bitonic_merge_network_p: a P=4 ascending instance
// checked against a scoreboard, plus P=2 descending and P=1 instances.
`timescale 1ns/1ps
module tb_bitonic_merge_network_p;

    localparam int DW  = 16;
    localparam int KW  = 8;
    localparam int P   = 4;
    localparam int TW  = P * DW;
    localparam int TW2 = 2 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main P=4 ascending instance
    logic          stall, i_valid, switch_output;
    logic [TW-1:0] top_tuple, elems_a, elems_b;
    logic [TW-1:0] o_lo, o_hi, o_top;
    logic          o_valid, o_stall, o_switch;

    // P=2 descending instance
    logic           d_stall, d_valid, d_switch;
    logic [TW2-1:0] d_top, d_a, d_b;
    logic [TW2-1:0] d_o_lo, d_o_hi, d_o_top;
    logic           d_o_valid, d_o_stall, d_o_switch;

    // P=1 instance
    logic          s_stall, s_valid, s_switch;
    logic [DW-1:0] s_top, s_a, s_b;
    logic [DW-1:0] s_o_lo, s_o_hi, s_o_top;
    logic          s_o_valid, s_o_stall, s_o_switch;

    bitonic_merge_network_p #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .P(P), .DESCENDING(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .stall(stall), .i_valid(i_valid),
        .switch_output(switch_output), .top_tuple(top_tuple),
        .i_elems_0(elems_a), .i_elems_1(elems_b),
        .o_elems_0(o_lo), .o_elems_1(o_hi), .o_valid(o_valid), .o_stall(o_stall),
        .o_switch_output(o_switch), .o_top_tuple(o_top)
    );

    bitonic_merge_network_p #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .P(2), .DESCENDING(1'b1)) dut_desc (
        .i_clk(clk), .i_rst(rst), .stall(d_stall), .i_valid(d_valid),
        .switch_output(d_switch), .top_tuple(d_top),
        .i_elems_0(d_a), .i_elems_1(d_b),
        .o_elems_0(d_o_lo), .o_elems_1(d_o_hi), .o_valid(d_o_valid), .o_stall(d_o_stall),
        .o_switch_output(d_o_switch), .o_top_tuple(d_o_top)
    );

    bitonic_merge_network_p #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .P(1), .DESCENDING(1'b0)) dut_single (
        .i_clk(clk), .i_rst(rst), .stall(s_stall), .i_valid(s_valid),
        .switch_output(s_switch), .top_tuple(s_top),
        .i_elems_0(s_a), .i_elems_1(s_b),
        .o_elems_0(s_o_lo), .o_elems_1(s_o_hi), .o_valid(s_o_valid), .o_stall(s_o_stall),
        .o_switch_output(s_o_switch), .o_top_tuple(s_o_top)
    );

    typedef struct packed {
        logic [TW-1:0] lo;
        logic [TW-1:0] hi;
        logic          sw;
        logic [TW-1:0] top;
    } expect_t;

    expect_t sb[$];
    expect_t mon_item;
    int checks = 0;
    int passes = 0;

    // Every fresh output beat (valid, not a stalled repeat) must match the oldest expected tuple
    always @(negedge clk) begin
        if (o_valid && !o_stall) begin
            checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL sb_unexpected: got lo=%h hi=%h, required no output", o_lo, o_hi);
            end else begin
                mon_item = sb.pop_front();
                if (o_lo !== mon_item.lo || o_hi !== mon_item.hi ||
                    o_switch !== mon_item.sw || o_top !== mon_item.top) begin
                    $display("[TB] FAIL sb_data: got lo=%h hi=%h sw=%b top=%h, required lo=%h hi=%h sw=%b top=%h",
                             o_lo, o_hi, o_switch, o_top, mon_item.lo, mon_item.hi, mon_item.sw, mon_item.top);
                end else begin
                    passes++;
                end
            end
        end
    end

    // Drive the main instance and record the expected result if the tuple is accepted
    task automatic drive(input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic [TW-1:0] lo, input logic [TW-1:0] hi,
                         input logic sw, input logic [TW-1:0] top,
                         input logic valid, input logic st);
        expect_t item;
        elems_a       = a;
        elems_b       = b;
        switch_output = sw;
        top_tuple     = top;
        i_valid       = valid;
        stall         = st;
        if (valid && !st) begin
            item.lo  = lo;
            item.hi  = hi;
            item.sw  = sw;
            item.top = top;
            sb.push_back(item);
        end
    endtask

    // Build a random tuple pair with distinct keys; expected halves come from a plain sort
    task automatic make_tuple(output logic [TW-1:0] a, output logic [TW-1:0] b,
                              output logic [TW-1:0] lo, output logic [TW-1:0] hi);
        logic [7:0]  keys [8];
        logic [7:0]  tags [8];
        logic [7:0]  tmp;
        logic [15:0] elem;
        logic        dup;
        int          na;
        int          nb;
        for (int i = 0; i < 8; i++) begin
            do begin
                keys[i] = 8'($urandom_range(0, 255));
                dup = 1'b0;
                for (int j = 0; j < i; j++) begin
                    if (keys[j] == keys[i]) dup = 1'b1;
                end
            end while (dup);
            tags[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (keys[j] > keys[j+1]) begin
                    tmp = keys[j]; keys[j] = keys[j+1]; keys[j+1] = tmp;
                    tmp = tags[j]; tags[j] = tags[j+1]; tags[j+1] = tmp;
                end
            end
        end
        na = 0; nb = 0;
        a = '0; b = '0; lo = '0; hi = '0;
        for (int i = 0; i < 8; i++) begin
            elem = {tags[i], keys[i]};
            if (i < 4) lo[i*DW +: DW] = elem;
            else       hi[(i-4)*DW +: DW] = elem;
            if (nb == 4 || (na < 4 && $urandom_range(0, 1) == 1)) begin
                a[na*DW +: DW] = elem;
                na++;
            end else begin
                b[nb*DW +: DW] = elem;
                nb++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        d_stall = 0; d_valid = 0; d_switch = 0; d_top = '0; d_a = '0; d_b = '0;
        s_stall = 0; s_valid = 0; s_switch = 0; s_top = '0; s_a = '0; s_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_lo !== '0 || o_hi !== '0 || o_valid !== 1'b0 || o_stall !== 1'b0 ||
            o_switch !== 1'b0 || o_top !== '0) begin
            $display("[TB] FAIL reset_main: got lo=%h hi=%h v=%b st=%b sw=%b top=%h, required all 0",
                     o_lo, o_hi, o_valid, o_stall, o_switch, o_top);
        end else passes++;
        checks++;
        if (d_o_valid !== 1'b0 || s_o_valid !== 1'b0 || d_o_lo !== '0 || s_o_hi !== '0) begin
            $display("[TB] FAIL reset_small: got dv=%b sv=%b dlo=%h shi=%h, required 0",
                     d_o_valid, s_o_valid, d_o_lo, s_o_hi);
        end else passes++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [TW-1:0] a, b, lo, hi;
        a  = {16'hA309, 16'hA206, 16'hA104, 16'hA001};
        b  = {16'hB308, 16'hB207, 16'hB103, 16'hB002};
        lo = {16'hA104, 16'hB103, 16'hB002, 16'hA001};
        hi = {16'hA309, 16'hB308, 16'hB207, 16'hA206};
        @(negedge clk);
        drive(a, b, lo, hi, 1'b0, '0, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (c < 3) begin
                if (o_valid !== 1'b0) $display("[TB] FAIL basic_latency: cycle %0d got valid=%b, required 0", c, o_valid);
                else passes++;
            end else begin
                if (o_valid !== 1'b1 || o_lo !== lo || o_hi !== hi)
                    $display("[TB] FAIL basic_merge: got v=%b lo=%h hi=%h, required v=1 lo=%h hi=%h", o_valid, o_lo, o_hi, lo, hi);
                else passes++;
            end
        end
    endtask

    task automatic test_ties();
        logic [TW-1:0] a, b;
        a = {4{16'h0A05}};
        b = {4{16'h0B05}};
        @(negedge clk);
        drive(a, b, a, b, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_lo !== a || o_hi !== b)
            $display("[TB] FAIL ties: got v=%b lo=%h hi=%h, required v=1 lo=%h hi=%h", o_valid, o_lo, o_hi, a, b);
        else passes++;
    endtask

    task automatic test_stall();
        logic [TW-1:0] a0, b0, l0, h0, a1, b1, l1, h1, a2, b2, l2, h2;
        make_tuple(a0, b0, l0, h0);
        make_tuple(a1, b1, l1, h1);
        make_tuple(a2, b2, l2, h2);
        @(negedge clk);
        drive(a0, b0, l0, h0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        drive(a1, b1, l1, h1, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        drive(a2, b2, l2, h2, 1'b0, '0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_stall !== 1'b0 || o_lo !== l0)
            $display("[TB] FAIL stall_t0: got v=%b st=%b lo=%h, required v=1 st=0 lo=%h", o_valid, o_stall, o_lo, l0);
        else passes++;
        drive(a2, b2, l2, h2, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_lo !== l1)
            $display("[TB] FAIL stall_t1: got st=%b lo=%h, required st=0 lo=%h", o_stall, o_lo, l1);
        else passes++;
        drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b1 || o_lo !== l1)
            $display("[TB] FAIL stall_pulse: got st=%b lo=%h, required st=1 lo=%h", o_stall, o_lo, l1);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_valid !== 1'b1 || o_hi !== h2)
            $display("[TB] FAIL stall_t2: got st=%b v=%b hi=%h, required st=0 v=1 hi=%h", o_stall, o_valid, o_hi, h2);
        else passes++;
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL stall_drain: got %0d pending, required 0", sb.size());
        else passes++;
    endtask

    task automatic test_sideband();
        logic [TW-1:0] a0, b0, l0, h0, a1, b1, l1, h1, top1;
        make_tuple(a0, b0, l0, h0);
        make_tuple(a1, b1, l1, h1);
        top1 = {$urandom, $urandom};
        @(negedge clk);
        drive(a0, b0, l0, h0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        @(negedge clk);
        drive(a1, b1, l1, h1, 1'b0, top1, 1'b1, 1'b0);
        @(negedge clk);
        drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (o_switch !== 1'b1 || o_top !== 64'h1234_5678_9ABC_DEF0 || o_lo !== l0)
            $display("[TB] FAIL sideband_t0: got sw=%b top=%h lo=%h, required sw=1 top=123456789abcdef0 lo=%h", o_switch, o_top, o_lo, l0);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_switch !== 1'b0 || o_top !== top1)
            $display("[TB] FAIL sideband_t1: got sw=%b top=%h, required sw=0 top=%h", o_switch, o_top, top1);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [TW-1:0] a, b, l, h;
        for (int t = 0; t < 3; t++) begin
            make_tuple(a, b, l, h);
            @(negedge clk);
            drive(a, b, l, h, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        end
        @(negedge clk);
        drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        checks++;
        if (o_lo !== '0 || o_hi !== '0 || o_valid !== 1'b0 || o_stall !== 1'b0 ||
            o_switch !== 1'b0 || o_top !== '0)
            $display("[TB] FAIL reset_mid: got lo=%h hi=%h v=%b st=%b sw=%b top=%h, required all 0",
                     o_lo, o_hi, o_valid, o_stall, o_switch, o_top);
        else passes++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_stall !== 1'b0)
                $display("[TB] FAIL reset_flush: cycle %0d got v=%b st=%b, required 0", c, o_valid, o_stall);
            else passes++;
        end
        make_tuple(a, b, l, h);
        drive(a, b, l, h, 1'b0, '0, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
            checks++;
            if ((c < 3 && o_valid !== 1'b0) || (c == 3 && (o_valid !== 1'b1 || o_lo !== l)))
                $display("[TB] FAIL reset_restart: cycle %0d got v=%b lo=%h, required v=%0d lo=%h", c, o_valid, o_lo, (c == 3), l);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] a, b, l, h;
        for (int t = 0; t < 40; t++) begin
            make_tuple(a, b, l, h);
            @(negedge clk);
            drive(a, b, l, h, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        drive('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL random_drain: got %0d pending, required 0", sb.size());
        else passes++;
    endtask

    task automatic test_descending_p2();
        @(negedge clk);
        d_a = {16'h0A03, 16'h0A09};
        d_b = {16'h0B01, 16'h0B08};
        d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        checks++;
        if (d_o_valid !== 1'b0) $display("[TB] FAIL desc_latency: got v=%b, required 0", d_o_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (d_o_valid !== 1'b1 || d_o_lo !== {16'h0B08, 16'h0A09} || d_o_hi !== {16'h0B01, 16'h0A03})
            $display("[TB] FAIL desc_merge: got v=%b lo=%h hi=%h, required v=1 lo=0b080a09 hi=0b010a03", d_o_valid, d_o_lo, d_o_hi);
        else passes++;
    endtask

    task automatic test_single_p1();
        @(negedge clk);
        s_a = 16'h0A07;
        s_b = 16'h0B02;
        s_switch = 1'b1;
        s_top = 16'hBEEF;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_switch = 1'b0;
        checks++;
        if (s_o_valid !== 1'b1 || s_o_lo !== 16'h0B02 || s_o_hi !== 16'h0A07 ||
            s_o_switch !== 1'b1 || s_o_top !== 16'hBEEF)
            $display("[TB] FAIL single_merge: got v=%b lo=%h hi=%h sw=%b top=%h, required v=1 lo=0b02 hi=0a07 sw=1 top=beef",
                     s_o_valid, s_o_lo, s_o_hi, s_o_switch, s_o_top);
        else passes++;
        @(negedge clk);
        checks++;
        if (s_o_valid !== 1'b0) $display("[TB] FAIL single_valid_drop: got v=%b, required 0", s_o_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_stall();
        test_sideband();
        test_reset_mid();
        test_back_to_back();
        test_descending_p2();
        test_single_p1();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL final_drain: got %0d pending, required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
